// File: rtl/clk_div_cfg_pkg.sv
// Shared types and constants for the UART clock-divider configuration controller.
package clk_div_cfg_pkg;

    // Sequencing states of the ratio-update controller.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        GATED  = 3'd2,
        LOAD   = 3'd3,
        RESUME = 3'd4
    } cfg_state_t;

    // Divider ratio applied out of reset.
    localparam int DEFAULT_RATIO = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after ptr.
// Purely combinational; the pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N_REQ  = 2,
    parameter int PTR_WD = 1
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [PTR_WD-1:0] ptr,
    output logic [N_REQ-1:0]  gnt
);

    // Walk the requesters in priority order starting at ptr; the first hit wins.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req[k] && (k == ((int'(ptr) + i) % N_REQ))) begin
                    gnt[k] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Configuration controller for the UART clock divider: arbitrates ratio updates
// and applies each one glitch-free by gating the divider around the ratio load.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | enable follows i_enable; requests granted round-robin
//   DRAIN  | wait for divided clock low (or enable already off / timeout)
//   GATED  | enable held low for SETTLE_CYC cycles before the load
//   LOAD   | new ratio driven onto the divider
//   RESUME | enable held low SETTLE_CYC more cycles, then re-enabled
module clk_div_cfg_ctrl
    import clk_div_cfg_pkg::*;
#(
    parameter int RATIO_WD    = 8,
    parameter int N_REQ       = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int RESET_RATIO = DEFAULT_RATIO,
    parameter int DRAIN_TMO   = 255
) (
    input  logic                      i_ref_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*RATIO_WD-1:0] i_req_ratio,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic                      i_div_clk_mon,
    output logic                      o_clk_en,
    output logic [RATIO_WD-1:0]       o_div_ratio,
    output logic                      o_busy,
    output logic                      o_cfg_done,
    output logic                      o_err
);

    localparam int PTR_WD    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DRAIN_CW  = $clog2(DRAIN_TMO + 1);
    localparam int SETTLE_CW = $clog2(SETTLE_CYC + 1);

    // Down-counters load N-1 so that the terminal count (zero) marks the Nth cycle.
    localparam logic [DRAIN_CW-1:0]  DRAIN_LOAD  = DRAIN_CW'(DRAIN_TMO - 1);
    localparam logic [SETTLE_CW-1:0] SETTLE_LOAD = SETTLE_CW'(SETTLE_CYC - 1);
    localparam logic [RATIO_WD-1:0]  RST_RATIO   = RATIO_WD'(RESET_RATIO);

    cfg_state_t            state, state_nxt;
    logic [PTR_WD-1:0]     rr_ptr, rr_ptr_nxt;
    logic [DRAIN_CW-1:0]   drain_cnt, drain_cnt_nxt;
    logic [SETTLE_CW-1:0]  settle_cnt, settle_cnt_nxt;
    logic [RATIO_WD-1:0]   ratio_lat, ratio_lat_nxt;
    logic [RATIO_WD-1:0]   div_ratio_nxt;
    logic                  clk_en_nxt;
    logic                  cfg_done_nxt;
    logic                  err_nxt;
    logic                  busy_nxt;
    logic [N_REQ-1:0]      gnt;
    logic                  hs;
    logic [RATIO_WD-1:0]   win_ratio;
    logic [PTR_WD-1:0]     win_ptr_nxt;

    rr_arbiter #(
        .N_REQ  (N_REQ),
        .PTR_WD (PTR_WD)
    ) u_arb (
        .req (i_req_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    // Grants are only offered while idle; a handshake is any asserted ready.
    assign o_req_ready = (state == IDLE) ? gnt : '0;
    assign hs          = |o_req_ready;

    // Select the winning requester's ratio and the pointer position just past it.
    always_comb begin
        win_ratio   = '0;
        win_ptr_nxt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                win_ratio   = i_req_ratio[k*RATIO_WD +: RATIO_WD];
                win_ptr_nxt = PTR_WD'((k + 1) % N_REQ);
            end
        end
    end

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        drain_cnt_nxt  = drain_cnt;
        settle_cnt_nxt = settle_cnt;
        ratio_lat_nxt  = ratio_lat;
        div_ratio_nxt  = o_div_ratio;
        clk_en_nxt     = o_clk_en;
        cfg_done_nxt   = 1'b0;
        err_nxt        = 1'b0;

        unique case (state)
            IDLE: begin
                clk_en_nxt = i_enable;
                if (hs) begin
                    ratio_lat_nxt = win_ratio;
                    rr_ptr_nxt    = win_ptr_nxt;
                    if (win_ratio == '0) begin
                        err_nxt = 1'b1;
                    end else if (win_ratio == o_div_ratio) begin
                        cfg_done_nxt = 1'b1;
                    end else begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                // Timeout covers ratio-1 bypass, where the monitored clock never rests low.
                if (!o_clk_en || !i_div_clk_mon || (drain_cnt == '0)) begin
                    state_nxt      = GATED;
                    clk_en_nxt     = 1'b0;
                    settle_cnt_nxt = SETTLE_LOAD;
                end else begin
                    drain_cnt_nxt = drain_cnt - DRAIN_CW'(1);
                end
            end
            GATED: begin
                clk_en_nxt = 1'b0;
                if (settle_cnt == '0) begin
                    state_nxt = LOAD;
                end else begin
                    settle_cnt_nxt = settle_cnt - SETTLE_CW'(1);
                end
            end
            LOAD: begin
                clk_en_nxt     = 1'b0;
                div_ratio_nxt  = ratio_lat;
                settle_cnt_nxt = SETTLE_LOAD;
                state_nxt      = RESUME;
            end
            RESUME: begin
                clk_en_nxt = 1'b0;
                if (settle_cnt == '0) begin
                    state_nxt    = IDLE;
                    clk_en_nxt   = i_enable;
                    cfg_done_nxt = 1'b1;
                end else begin
                    settle_cnt_nxt = settle_cnt - SETTLE_CW'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                clk_en_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State register.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs, counters, pointer and latched ratio.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr      <= '0;
            drain_cnt   <= '0;
            settle_cnt  <= '0;
            ratio_lat   <= '0;
            o_div_ratio <= RST_RATIO;
            o_clk_en    <= 1'b0;
            o_cfg_done  <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            rr_ptr      <= rr_ptr_nxt;
            drain_cnt   <= drain_cnt_nxt;
            settle_cnt  <= settle_cnt_nxt;
            ratio_lat   <= ratio_lat_nxt;
            o_div_ratio <= div_ratio_nxt;
            o_clk_en    <= clk_en_nxt;
            o_cfg_done  <= cfg_done_nxt;
            o_err       <= err_nxt;
            o_busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: table vectors, random transactions
// against a timing model, and hand-written arbitration / reset sequences.
module tb_clk_div_cfg_ctrl;

    localparam int RW  = 8;
    localparam int NR  = 2;
    localparam int S   = 4;
    localparam int TMO = 255;
    localparam int RR  = 16;

    logic             i_ref_clk = 1'b0;
    logic             i_rst;
    logic             i_enable;
    logic [NR-1:0]    i_req_valid;
    logic [NR*RW-1:0] i_req_ratio;
    logic [NR-1:0]    o_req_ready;
    logic             i_div_clk_mon;
    logic             o_clk_en;
    logic [RW-1:0]    o_div_ratio;
    logic             o_busy;
    logic             o_cfg_done;
    logic             o_err;

    int checks   = 0;
    int failures = 0;

    always #5 i_ref_clk = ~i_ref_clk;

    clk_div_cfg_ctrl #(
        .RATIO_WD    (RW),
        .N_REQ       (NR),
        .SETTLE_CYC  (S),
        .RESET_RATIO (RR),
        .DRAIN_TMO   (TMO)
    ) dut (
        .i_ref_clk     (i_ref_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_req_valid   (i_req_valid),
        .i_req_ratio   (i_req_ratio),
        .o_req_ready   (o_req_ready),
        .i_div_clk_mon (i_div_clk_mon),
        .o_clk_en      (o_clk_en),
        .o_div_ratio   (o_div_ratio),
        .o_busy        (o_busy),
        .o_cfg_done    (o_cfg_done),
        .o_err         (o_err)
    );

    typedef struct {
        int          req;
        logic [7:0]  ratio;
        logic        mon;
        logic        en;
        int          exp_done;
        int          exp_err;
        int          exp_low;
        logic [7:0]  exp_ratio;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Expected outcome derived from the documented sequence lengths.
    task automatic model(input logic [7:0] r, input logic [7:0] cur, input logic mon, input logic en,
                         output int done_at, output int err_at, output int low, output logic [7:0] nxt);
        int drain;
        done_at = 0;
        err_at  = 0;
        nxt     = cur;
        if (r == 0) begin
            err_at = 1;
            low    = en ? 0 : 1;
        end else if (r == cur) begin
            done_at = 1;
            low     = en ? 0 : 1;
        end else begin
            drain   = (mon && en) ? TMO : 1;
            done_at = drain + 2*S + 2;
            low     = en ? 2*S + 1 : done_at;
            nxt     = r;
        end
    endtask

    task automatic apply_reset();
        i_rst         = 1'b1;
        i_req_valid   = '0;
        i_req_ratio   = '0;
        i_enable      = 1'b0;
        i_div_clk_mon = 1'b0;
        repeat (2) @(negedge i_ref_clk);
        i_rst = 1'b0;
        @(negedge i_ref_clk);
    endtask

    // One request from requester k; observes timing of done/err, gated cycles and ratio changes.
    task automatic run_txn(input int k, input logic [7:0] r, input logic mon, input logic en,
                           input int exp_done, input int exp_err, input int exp_low,
                           input logic [7:0] exp_ratio, input string tag);
        int wait_cyc, done_at, err_at, low, glitch, dn, ne, win;
        logic [7:0] prev;
        logic prev_en, busy1;
        @(negedge i_ref_clk);
        i_enable      = en;
        i_div_clk_mon = mon;
        @(negedge i_ref_clk);
        i_req_valid              = '0;
        i_req_valid[k]           = 1'b1;
        i_req_ratio[k*RW +: RW]  = r;
        #1;
        wait_cyc = 0;
        while (o_req_ready[k] !== 1'b1 && wait_cyc < 50) begin
            @(negedge i_ref_clk);
            #1;
            wait_cyc++;
        end
        check({tag, "_grant"}, 32'(o_req_ready), 32'(1 << k));
        prev    = o_div_ratio;
        prev_en = o_clk_en;
        @(negedge i_ref_clk);
        i_req_valid = '0;
        done_at = 0; err_at = 0; low = 0; glitch = 0; dn = 0; ne = 0; busy1 = 1'b0;
        win = (exp_done > exp_err) ? exp_done : exp_err;
        for (int n = 1; n <= win + 2; n++) begin
            if (n == 1) busy1 = o_busy;
            if (o_cfg_done === 1'b1) begin dn++; if (done_at == 0) done_at = n; end
            if (o_err === 1'b1) begin ne++; if (err_at == 0) err_at = n; end
            if (n <= win && o_clk_en !== 1'b1) low++;
            if (o_div_ratio !== prev && (o_clk_en !== 1'b0 || prev_en !== 1'b0)) glitch++;
            prev    = o_div_ratio;
            prev_en = o_clk_en;
            @(negedge i_ref_clk);
        end
        check({tag, "_done_at"}, 32'(done_at), 32'(exp_done));
        check({tag, "_err_at"}, 32'(err_at), 32'(exp_err));
        check({tag, "_done_cnt"}, 32'(dn), 32'(exp_done != 0));
        check({tag, "_err_cnt"}, 32'(ne), 32'(exp_err != 0));
        check({tag, "_busy1"}, 32'(busy1), 32'(exp_done > 1));
        check({tag, "_low_cyc"}, 32'(low), 32'(exp_low));
        check({tag, "_glitch"}, 32'(glitch), 32'd0);
        check({tag, "_ratio"}, 32'(o_div_ratio), 32'(exp_ratio));
        check({tag, "_en_end"}, 32'(o_clk_en), 32'(en));
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cur, r, rnxt;
        logic        mon, en;
        int          k, dn, ng, d_at, e_at, lw;
        logic [1:0]  gord[3];

        // Reset values and one-cycle enable follow.
        i_rst = 1'b1; i_req_valid = '0; i_req_ratio = '0; i_enable = 1'b0; i_div_clk_mon = 1'b0;
        #1;
        check("rst_clk_en", 32'(o_clk_en), 32'd0);
        check("rst_ratio", 32'(o_div_ratio), 32'(RR));
        check("rst_ready", 32'(o_req_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_cfg_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        repeat (2) @(negedge i_ref_clk);
        i_rst = 1'b0;
        @(negedge i_ref_clk);
        i_enable = 1'b1;
        #1;
        check("en_before_edge", 32'(o_clk_en), 32'd0);
        @(negedge i_ref_clk);
        check("en_follow", 32'(o_clk_en), 32'd1);
        check("en_ratio", 32'(o_div_ratio), 32'(RR));
        check("en_busy", 32'(o_busy), 32'd0);

        // req, ratio, mon, en, done_at, err_at, low cycles, ratio after
        tbl[0] = '{0, 8'd8,   1'b0, 1'b1, 11,  0, 9,  8'd8};
        tbl[1] = '{1, 8'd0,   1'b0, 1'b1, 0,   1, 0,  8'd8};
        tbl[2] = '{0, 8'd8,   1'b1, 1'b1, 1,   0, 0,  8'd8};
        tbl[3] = '{1, 8'd1,   1'b0, 1'b1, 11,  0, 9,  8'd1};
        tbl[4] = '{0, 8'd16,  1'b1, 1'b1, 265, 0, 9,  8'd16};
        tbl[5] = '{1, 8'd16,  1'b0, 1'b1, 1,   0, 0,  8'd16};
        tbl[6] = '{1, 8'd200, 1'b1, 1'b0, 11,  0, 11, 8'd200};
        tbl[7] = '{0, 8'd0,   1'b1, 1'b0, 0,   1, 1,  8'd200};
        tbl[8] = '{1, 8'd200, 1'b0, 1'b0, 1,   0, 1,  8'd200};
        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].req, tbl[i].ratio, tbl[i].mon, tbl[i].en, tbl[i].exp_done,
                    tbl[i].exp_err, tbl[i].exp_low, tbl[i].exp_ratio, $sformatf("vec%0d", i));
        end

        // Random transactions against the timing model.
        cur = 8'd200;
        for (int i = 0; i < 24; i++) begin
            k = int'($urandom_range(0, NR - 1));
            case ($urandom_range(0, 9))
                0:       r = 8'd0;
                1:       r = cur;
                2:       r = 8'd1;
                default: r = 8'($urandom_range(1, 255));
            endcase
            mon = ($urandom_range(0, 7) == 0);
            en  = 1'($urandom_range(0, 1));
            model(r, cur, mon, en, d_at, e_at, lw, rnxt);
            run_txn(k, r, mon, en, d_at, e_at, lw, rnxt, $sformatf("rnd%0d", i));
            cur = rnxt;
        end

        // Simultaneous held requests: strict alternation from pointer 0.
        apply_reset();
        i_enable = 1'b1;
        @(negedge i_ref_clk);
        i_req_ratio = {8'd10, 8'd6};
        i_req_valid = 2'b11;
        ng = 0; dn = 0;
        gord[0] = '0; gord[1] = '0; gord[2] = '0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (o_req_ready != '0 && ng < 3) begin
                gord[ng] = o_req_ready;
                ng++;
            end
            @(negedge i_ref_clk);
            if (ng == 3) i_req_valid = '0;
            if (o_cfg_done === 1'b1) dn++;
        end
        check("rr_first", 32'(gord[0]), 32'd1);
        check("rr_second", 32'(gord[1]), 32'd2);
        check("rr_third", 32'(gord[2]), 32'd1);
        check("rr_done_cnt", 32'(dn), 32'd3);
        check("rr_ratio", 32'(o_div_ratio), 32'd6);

        // Reset asserted while gated.
        apply_reset();
        i_enable = 1'b1;
        @(negedge i_ref_clk);
        i_req_ratio[RW-1:0] = 8'd8;
        i_req_valid = 2'b01;
        @(negedge i_ref_clk);
        i_req_valid = '0;
        repeat (2) @(negedge i_ref_clk);
        check("gated_busy", 32'(o_busy), 32'd1);
        check("gated_en", 32'(o_clk_en), 32'd0);
        i_rst = 1'b1;
        #1;
        check("rst_mid_ratio", 32'(o_div_ratio), 32'(RR));
        check("rst_mid_en", 32'(o_clk_en), 32'd0);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        @(negedge i_ref_clk);
        i_rst = 1'b0;
        repeat (12) @(negedge i_ref_clk);
        check("rst_after_ratio", 32'(o_div_ratio), 32'(RR));
        check("rst_after_en", 32'(o_clk_en), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
